// File: rtl/alu_req_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// One op in flight: latch operands, pulse the ALU enable for one cycle, return the result.
module alu_req_arbiter #(
  parameter int            DW      = 8,
  parameter int            CW      = 4,
  parameter logic [CW-1:0] DIV_CMD = 4'b0101
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [DW-1:0]   req0_a,
  input  logic [DW-1:0]   req0_b,
  input  logic [CW-1:0]   req0_cmd,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [DW-1:0]   req1_a,
  input  logic [DW-1:0]   req1_b,
  input  logic [CW-1:0]   req1_cmd,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic            resp_id,
  output logic [2*DW-1:0] resp_data,
  output logic            resp_err,
  output logic [DW-1:0]   alu_a,
  output logic [DW-1:0]   alu_b,
  output logic [CW-1:0]   alu_cmd,
  output logic            alu_oe,
  input  logic [2*DW-1:0] alu_d,
  output logic            busy,
  output logic [15:0]     op_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t        state;
  logic          last_grant;
  logic          grant;
  logic          accept;
  logic          div_trap;
  logic [DW-1:0] sel_a;
  logic [DW-1:0] sel_b;
  logic [CW-1:0] sel_cmd;

  // A lone requester always wins; on contention the one not served last time wins.
  always_comb begin
    grant = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
  end

  // Readies are gated by rst_n so nothing is offered while reset is asserted.
  assign accept     = rst_n && (state == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = accept && !grant;
  assign req1_ready = accept && grant;

  assign sel_a    = grant ? req1_a   : req0_a;
  assign sel_b    = grant ? req1_b   : req0_b;
  assign sel_cmd  = grant ? req1_cmd : req0_cmd;
  assign div_trap = (sel_cmd == DIV_CMD) && (sel_b == '0);

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_cmd    <= '0;
      alu_oe     <= 1'b0;
      op_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_a      <= sel_a;
            alu_b      <= sel_b;
            alu_cmd    <= sel_cmd;
            resp_id    <= grant;
            last_grant <= grant;
            if (div_trap) begin
              // Trapped ops bypass the ALU entirely.
              resp_data  <= '0;
              resp_err   <= 1'b1;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else begin
              alu_oe <= 1'b1;
              state  <= ISSUE;
            end
          end
        end
        ISSUE: begin
          alu_oe     <= 1'b0;
          resp_data  <= alu_d;
          resp_err   <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
            if (op_count != 16'hFFFF) op_count <= op_count + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
- Sequences and shares one combinational 8-bit ALU (16-bit tri-stated result, 4-bit command, output enable) between two requesters.
- Arbitrates round-robin, latches operands and drives the ALU, asserting its output enable only during the issue cycle.
- Captures the result and returns it on a single shared response channel with requester ID and an error flag.
- Sits between the command sources and the ALU instance in the datapath.

Parameters:
- DW, 8, operand width on the request side and ALU input side.
- CW, 4, command width.
- DIV_CMD, 4'b0101, command code trapped for divide-by-zero.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_a, req0_b  input  DW each  requester 0 operands.
- req0_cmd  input  CW  requester 0 ALU command.
- req1_valid, req1_ready, req1_a, req1_b, req1_cmd: same as requester 0, for requester 1.
- resp_valid  output  1  response available.
- resp_ready  input  1  consumer takes the response.
- resp_id  output  1  requester that issued the response (0/1).
- resp_data  output  2*DW  captured ALU result.
- resp_err  output  1  divide-by-zero trapped.
- alu_a, alu_b  output  DW each  ALU operands.
- alu_cmd  output  CW  ALU command.
- alu_oe  output  1  ALU output enable.
- alu_d  input  2*DW  ALU result bus; Z when alu_oe=0.
- busy  output  1  state != IDLE.
- op_count  output  16  completed responses, saturating.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset (async, rst_n=0), all regs clear:
  - state=IDLE; all outputs 0 (req*_ready, resp_valid, resp_id, resp_data, resp_err, alu_a, alu_b, alu_cmd, alu_oe, busy, op_count).
  - last_grant=1, so requester 0 wins first.
  - Reset mid-operation discards the in-flight op; no response is produced.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - Grant selection: only req0_valid → 0; only req1_valid → 1; both → the requester != last_grant.
  - reqN_ready is combinational: (state==IDLE) && grant==N. At most one ready per cycle; never asserted outside IDLE.
  - On handshake: latch a, b, cmd into alu_a/alu_b/alu_cmd; resp_id←N; last_grant←N.
  - Divide-by-zero (cmd==DIV_CMD and b==0): go to RESP with resp_data=16'h0000, resp_err=1. No ALU issue; alu_oe stays 0.
  - Otherwise go to ISSUE.
- ISSUE (exactly 1 cycle):
  - alu_oe=1 (registered; high only while state==ISSUE).
  - On the clock edge: resp_data←alu_d, resp_err←0; go to RESP.
  - alu_d is never sampled in any other state.
- RESP:
  - resp_valid=1; resp_data, resp_id and resp_err held stable until resp_ready.
  - On resp_valid && resp_ready: go to IDLE; op_count+1, saturating at 16'hFFFF.
  - No new request is accepted in the cycle of the response handshake; acceptance resumes next cycle in IDLE.
- alu_a, alu_b, alu_cmd: hold their last latched values outside ISSUE; no glitching.
- Latency:
  - Normal op: handshake edge T → ISSUE in cycle T+1 → resp_valid from cycle T+2.
  - Div-by-zero trap: resp_valid from cycle T+1.
- Requests held valid while the block is busy wait; requests are never dropped.
- Throughput: at most one operation in flight. Minimum 3 cycles per normal op, 2 per trapped op.
- Back-to-back with both requesters valid continuously: grants alternate 0,1,0,1.

Test Plan:
- Reset, then req0: a=8'h12, b=8'h34, cmd ADD → req0_ready 1 cycle; alu_oe high exactly 1 cycle; resp_valid 2 cycles after handshake; resp_data=16'h0046, resp_id=0, resp_err=0; op_count=1.
- req0 and req1 both held valid: req0 MUL 8'h0F×8'h10, req1 SUB 8'h20−8'h01 → order id0 (16'h00F0), id1 (16'h001F), id0, id1, ...; never two readies in one cycle.
- req1: DIV, a=8'h40, b=8'h00 → response 1 cycle after handshake; resp_data=0, resp_err=1; alu_oe never rises. Then DIV 8'h40/8'h08 → 16'h0008, err=0.
- Response backpressure: hold resp_ready=0 for 5 cycles with req0 valid → resp_data/id stable; req0_ready stays 0; alu_oe 0; busy 1. Release → next op accepted the following cycle.
- Assert rst_n low during ISSUE → all outputs 0 immediately (async), no response emitted. After release, a fresh req1 is accepted if req1 alone is valid; if both are valid, req0 wins.
- Force op_count to 16'hFFFE via 2 final ops → value stops at 16'hFFFF on further responses.
